loop_count_ctrl: RTL and testbench
==================================

# loop_count_ctrl

Loadable down-counting loop controller for the 8-bit ALU datapath. It accepts an iteration count, decrements it once per enabled step, and reports when the count reaches zero. Multi-cycle ALU sequences (repeated shift, iterative add) use it to decide when to stop. It is the producing side of the zero-flag path: it generates the count values that the zero detection judges, and it holds a registered zero condition for the sequencer.

## Interface
- WIDTH, 8, width of the count and of ITER
- CLK  input  1  rising-edge clock
- RST_N  input  1  reset, asynchronous, active-low
- START  input  1  load request; sampled only in IDLE
- COUNT  input  WIDTH  iteration count, sampled with START
- STEP_EN  input  1  advance one iteration; honoured only in RUN
- ABORT  input  1  cancel the loop; honoured only in RUN
- ITER  output  WIDTH  remaining iterations (count register)
- ZERO  output  1  high when ITER == 0
- BUSY  output  1  high in RUN
- DONE  output  1  one-cycle pulse on normal completion
- ABORTED  output  1  one-cycle pulse on abort

One clock; reset is asynchronous and active-low.

## Operation
- States:
  - IDLE: waiting for a load.
  - RUN: counting down.
  - FIN: normal completion, lasts one cycle.
  - ABT: aborted, lasts one cycle.
- IDLE transitions:
  - START=1 and COUNT≠0: load the count register with COUNT, go to RUN.
  - START=1 and COUNT=0: load 0, go to FIN (zero-trip loop).
- RUN transitions, in priority order:
  - ABORT=1: go to ABT. The count register holds its value and no decrement occurs, even if STEP_EN=1 in the same cycle. Abort wins over a final step.
  - STEP_EN=1 with count=1: count becomes 0, go to FIN.
  - STEP_EN=1 otherwise: count decrements by 1.
  - STEP_EN=0: hold.
- FIN and ABT always go to IDLE on the next edge. The count register holds its value in both.
- START is ignored outside IDLE. No queueing, no error flag.
- STEP_EN and ABORT are ignored outside RUN.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - The decrement never wraps: RUN is never entered with count 0, and the decrement from 1 exits RUN.
- Outputs are decoded from the registers:
  - ITER = count register.
  - ZERO = (count == 0).
  - BUSY = (state == RUN).
  - DONE = (state == FIN).
  - ABORTED = (state == ABT).
- Reset, at any time including mid-loop: state IDLE, count 0. This gives ITER=0, ZERO=1, BUSY=0, DONE=0, ABORTED=0. No pulse is emitted on reset.

## Timing
- Load latency: START sampled at edge k; BUSY (or DONE for COUNT=0) is visible after edge k.
- With STEP_EN held high and COUNT=N≥1:
  - RUN occupies N cycles.
  - ITER steps N, N-1, …, 1.
  - DONE is high in the cycle after the Nth step edge, with ITER=0.
  - IDLE resumes one cycle later.
- Minimum restart spacing: the earliest next START is the cycle after FIN or ABT. Back-to-back loops cost exactly one FIN cycle of overhead.
- Outputs change only on the CLK rising edge or on the RST_N assertion edge.

## Structure
- Package loop_count_pkg holds:
  - the state encoding constants ST_IDLE, ST_RUN, ST_FIN, ST_ABT (2-bit);
  - the default WIDTH constant.
- Sub-module cnt_zero_det: a parameterized WIDTH-bit zero detector, purely combinational, driving ZERO and the count==1 compare (the compare is done on count-1). The rest is one FSM plus the count register in the top module.

## Test plan
- Reset and idle:
  - Assert RST_N=0 mid-RUN with ITER=5 → immediately ITER=0, ZERO=1, BUSY=0, and no DONE or ABORTED pulse.
  - After release with idle inputs → IDLE holds.
- Nominal loop:
  - START with COUNT=3, STEP_EN=1 continuously → BUSY for 3 cycles, ITER 3, 2, 1.
  - Then DONE=1 for one cycle with ITER=0 and ZERO=1, then IDLE.
- Zero-trip loop:
  - START with COUNT=0 → BUSY never asserts.
  - DONE=1 in the next cycle, ZERO=1 throughout.
- Stalled stepping:
  - COUNT=2 with STEP_EN pulsed every other cycle → ITER holds between pulses.
  - DONE follows the second pulse; total RUN is 4 cycles.
- Abort priority:
  - COUNT=1, then ABORT=1 and STEP_EN=1 in the first RUN cycle → ABORTED=1, DONE=0, ITER remains 1, then IDLE.
- Ignored inputs:
  - START with COUNT=9 during RUN with ITER=4 → ITER continues 3, 2, … unchanged by the load.
  - STEP_EN in IDLE → ITER does not move.
  - WIDTH=8, COUNT=255 → exactly 255 RUN cycles with STEP_EN held high.

Source files
------------

// File: rtl/loop_count_pkg.sv
// Shared definitions for the loop count controller: state encoding and default count width.
package loop_count_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_ABT  = 2'd3
    } state_t;

endpackage : loop_count_pkg

// File: rtl/cnt_zero_det.sv
// Combinational zero detector for the count register; also flags count==1 by testing count-1 for zero.
module cnt_zero_det #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [WIDTH-1:0] value_dec;

    // A zero input wraps to all-ones here, so one_o stays low for it.
    assign value_dec = value_i - WIDTH'(1);
    assign zero_o    = (value_i == '0);
    assign one_o     = (value_dec == '0);

endmodule : cnt_zero_det

// File: rtl/loop_count_ctrl.sv
// Loadable down-counting loop controller: loads an iteration count, steps it down in RUN,
// and pulses DONE on normal completion or ABORTED on cancel.
module loop_count_ctrl
    import loop_count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             step_en_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] iter_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             cnt_zero;
    logic             cnt_one;

    cnt_zero_det #(
        .WIDTH (WIDTH)
    ) u_zero_det (
        .value_i (count_q),
        .zero_o  (cnt_zero),
        .one_o   (cnt_one)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    count_d = count_i;
                    state_d = (count_i == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort outranks a step, including the final one.
                if (abort_i) begin
                    state_d = ST_ABT;
                end else if (step_en_i) begin
                    count_d = count_q - WIDTH'(1);
                    if (cnt_one) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            ST_ABT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign iter_o    = count_q;
    assign zero_o    = cnt_zero;
    assign busy_o    = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_FIN);
    assign aborted_o = (state_q == ST_ABT);

endmodule : loop_count_ctrl

// File: tb/tb_loop_count_ctrl.sv
// Self-checking bench for loop_count_ctrl: a reference model feeds a scoreboard queue each cycle,
// and each scenario task adds its own explicit checks of the behaviour it targets.
module tb_loop_count_ctrl;

    localparam int W = 8;
    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_FIN = 2'd2, M_ABT = 2'd3;

    typedef struct packed {
        logic [W-1:0] iter;
        logic         zero;
        logic         busy;
        logic         done;
        logic         aborted;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] count = '0;
    logic         step_en = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] iter;
    logic         zero, busy, done, aborted;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;
    exp_t sb_q[$];

    logic [1:0]   mdl_state = M_IDLE;
    logic [W-1:0] mdl_count = '0;

    loop_count_ctrl #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .count_i   (count),
        .step_en_i (step_en),
        .abort_i   (abort),
        .iter_o    (iter),
        .zero_o    (zero),
        .busy_o    (busy),
        .done_o    (done),
        .aborted_o (aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got n_vec=%0d required completion", n_vec);
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: outputs are registered, so sample on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_txn++;
            n_vec++;
            if ({iter, zero, busy, done, aborted} !== e) begin
                n_err++;
                $display("FAIL scoreboard txn %0d: got iter=%0d z=%b b=%b d=%b a=%b, required iter=%0d z=%b b=%b d=%b a=%b",
                         n_txn, iter, zero, busy, done, aborted,
                         e.iter, e.zero, e.busy, e.done, e.aborted);
            end else begin
                $display("txn %0d: iter=%0d zero=%b busy=%b done=%b aborted=%b",
                         n_txn, iter, zero, busy, done, aborted);
            end
        end
    end

    // One clock of stimulus: advance the reference model, queue its outputs, cross the edge.
    task automatic drive_cycle(input logic s, input logic [W-1:0] c, input logic se, input logic ab);
        exp_t e;
        start = s; count = c; step_en = se; abort = ab;
        case (mdl_state)
            M_IDLE: if (s) begin
                mdl_count = c;
                mdl_state = (c == 0) ? M_FIN : M_RUN;
            end
            M_RUN: begin
                if (ab) mdl_state = M_ABT;
                else if (se) begin
                    if (mdl_count == 1) mdl_state = M_FIN;
                    mdl_count = mdl_count - 1;
                end
            end
            default: mdl_state = M_IDLE;
        endcase
        e.iter    = mdl_count;
        e.zero    = (mdl_count == 0);
        e.busy    = (mdl_state == M_RUN);
        e.done    = (mdl_state == M_FIN);
        e.aborted = (mdl_state == M_ABT);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; step_en = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({iter, zero, busy, done, aborted} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_initial: got iter=%0d z=%b b=%b d=%b a=%b, required iter=0 z=1 b=0 d=0 a=0",
                     iter, zero, busy, done, aborted);
        end
        @(negedge clk); #1 rst_n = 1'b1;
        drive_cycle(1'b1, 8'd7, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        n_vec++;
        if (iter !== 8'd5 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_setup: got iter=%0d busy=%b, required iter=5 busy=1", iter, busy);
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({iter, zero, busy, done, aborted} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_midrun: got iter=%0d z=%b b=%b d=%b a=%b, required iter=0 z=1 b=0 d=0 a=0",
                     iter, zero, busy, done, aborted);
        end
        mdl_state = M_IDLE;
        mdl_count = '0;
        #1 rst_n = 1'b1;
        n_vec++;
        if (done !== 1'b0 || aborted !== 1'b0) begin
            n_err++;
            $display("FAIL reset_nopulse: got done=%b aborted=%b, required 0 0", done, aborted);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'd3, 1'b0, 1'b1);
    endtask

    task automatic test_nominal();
        logic [W-1:0] seen[3];
        int           nbusy = 0;
        drive_cycle(1'b1, 8'd3, 1'b1, 1'b0);
        for (int i = 0; i < 10 && busy === 1'b1; i++) begin
            if (nbusy < 3) seen[nbusy] = iter;
            nbusy++;
            drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        end
        n_vec++;
        if (nbusy != 3 || seen[0] !== 8'd3 || seen[1] !== 8'd2 || seen[2] !== 8'd1) begin
            n_err++;
            $display("FAIL nominal_seq: got busy_cycles=%0d iters=%0d,%0d,%0d, required 3 cycles 3,2,1",
                     nbusy, seen[0], seen[1], seen[2]);
        end
        n_vec++;
        if (done !== 1'b1 || iter !== 8'd0 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL nominal_done: got done=%b iter=%0d zero=%b, required 1 0 1", done, iter, zero);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_trip();
        drive_cycle(1'b1, 8'd0, 1'b0, 1'b0);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL zero_trip: got done=%b busy=%b zero=%b, required 1 0 1", done, busy, zero);
        end
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        int nbusy = 0;
        drive_cycle(1'b1, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < 10 && busy === 1'b1; i++) begin
            nbusy++;
            drive_cycle(1'b0, 8'd0, logic'(i % 2), 1'b0);
            if (i == 0 || i == 2) begin
                n_vec++;
                if (iter !== ((i == 0) ? 8'd2 : 8'd1)) begin
                    n_err++;
                    $display("FAIL stall_hold: got iter=%0d at gap %0d, required %0d", iter, i, (i == 0) ? 2 : 1);
                end
            end
        end
        n_vec++;
        if (nbusy != 4 || done !== 1'b1) begin
            n_err++;
            $display("FAIL stall_len: got busy_cycles=%0d done=%b, required 4 and done=1", nbusy, done);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        drive_cycle(1'b1, 8'd1, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b1);
        n_vec++;
        if (aborted !== 1'b1 || done !== 1'b0 || iter !== 8'd1) begin
            n_err++;
            $display("FAIL abort_prio: got aborted=%b done=%b iter=%0d, required 1 0 1", aborted, done, iter);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b1);
        n_vec++;
        if (busy !== 1'b0 || aborted !== 1'b0 || iter !== 8'd1) begin
            n_err++;
            $display("FAIL abort_idle: got busy=%b aborted=%b iter=%0d, required 0 0 1", busy, aborted, iter);
        end
    endtask

    task automatic test_ignored();
        drive_cycle(1'b1, 8'd6, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'd9, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'd9, 1'b1, 1'b0);
        n_vec++;
        if (iter !== 8'd2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_run: got iter=%0d busy=%b, required iter=2 busy=1", iter, busy);
        end
        for (int i = 0; i < 10 && busy === 1'b1; i++) drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        n_vec++;
        if (iter !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL step_in_idle: got iter=%0d busy=%b, required iter=0 busy=0", iter, busy);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 8'd1, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'd4, 1'b0, 1'b0);
        n_vec++;
        if (busy !== 1'b0 || iter !== 8'd0) begin
            n_err++;
            $display("FAIL start_in_fin: got busy=%b iter=%0d, required 0 0", busy, iter);
        end
        drive_cycle(1'b1, 8'd4, 1'b0, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || iter !== 8'd4) begin
            n_err++;
            $display("FAIL restart: got busy=%b iter=%0d, required 1 4", busy, iter);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b1);
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_max();
        int nbusy = 0;
        drive_cycle(1'b1, 8'd255, 1'b1, 1'b0);
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            nbusy++;
            drive_cycle(1'b0, 8'd0, 1'b1, 1'b0);
        end
        n_vec++;
        if (nbusy != 255 || done !== 1'b1 || iter !== 8'd0) begin
            n_err++;
            $display("FAIL max_count: got busy_cycles=%0d done=%b iter=%0d, required 255 1 0", nbusy, done, iter);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        test_reset();
        test_nominal();
        test_zero_trip();
        test_stall();
        test_abort();
        test_ignored();
        test_back_to_back();
        test_max();
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_loop_count_ctrl
